digital_lock_fsm: RTL and testbench

// Keypad digital-lock controller: a registered Moore FSM that checks an
// 8-digit hexadecimal code entered one key per clock.
// It sits between the keypad decoder (keyout) and the lock actuator/alarm

---
 rtl/digital_lock_fsm.sv | 77 +++++++
 tb/tb_digital_lock_fsm.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/digital_lock_fsm.sv
// Keypad digital-lock controller: registered Moore FSM checking an 8-digit hex code
// entered one key per clock. The exported state is decoded by actuator/alarm logic.
//
// state | meaning
// LS0-7 | 0..7 code digits matched so far
// OPEN  | full code matched, lock released until LOCK key
// ALARM | wrong digit entered; sticky until reset
// INIT  | idle after reset, waiting for LOCK key to arm entry
module digital_lock_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  keyout,
    input  logic [31:0] seq,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        LS0   = 4'd0,
        LS1   = 4'd1,
        LS2   = 4'd2,
        LS3   = 4'd3,
        LS4   = 4'd4,
        LS5   = 4'd5,
        LS6   = 4'd6,
        LS7   = 4'd7,
        OPEN  = 4'd8,
        ALARM = 4'd9,
        INIT  = 4'd10
    } state_t;

    state_t     cur;
    logic       key_lock;
    logic       key_digit;
    logic [3:0] digit;

    assign key_lock  = (keyout == 5'd16);
    assign key_digit = ~keyout[4];

    // Digit n sits at bit offset 28-4n; ~n*4 yields exactly that for n in 0..7.
    assign digit = seq[{~cur[2:0], 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= INIT;
        end else begin
            case (cur)
                INIT: begin
                    if (key_lock) cur <= LS0;
                end
                LS0, LS1, LS2, LS3, LS4, LS5, LS6, LS7: begin
                    if (key_lock) begin
                        cur <= LS0;
                    end else if (key_digit) begin
                        if (keyout[3:0] != digit)
                            cur <= ALARM;
                        else if (cur == LS7)
                            cur <= OPEN;
                        else
                            cur <= state_t'(cur + 4'd1);
                    end
                end
                OPEN: begin
                    if (key_lock) cur <= LS0;
                end
                ALARM: begin
                    cur <= ALARM;
                end
                default: begin
                    cur <= INIT;
                end
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_digital_lock_fsm.sv
// Self-checking bench for digital_lock_fsm: directed scenarios followed by random
// key traffic compared against a behavioural lock model.
module tb_digital_lock_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  keyout = 5'd0;
    logic [31:0] seq = 32'h12345678;
    logic [3:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: how many digits matched, plus mode flags.
    int matched;
    bit m_init, m_open, m_alarm;

    digital_lock_fsm dut (
        .clk    (clk),
        .rst    (rst),
        .keyout (keyout),
        .seq    (seq),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_state();
        if (m_init)  return 4'd10;
        if (m_alarm) return 4'd9;
        if (m_open)  return 4'd8;
        return 4'(matched);
    endfunction

    function automatic logic [3:0] code_digit(input int n);
        return 4'((seq >> (28 - 4 * n)) & 32'hF);
    endfunction

    task automatic model_reset();
        m_init = 1; m_open = 0; m_alarm = 0; matched = 0;
    endtask

    task automatic model_step(input logic [4:0] k);
        if (m_alarm) return;
        if (m_init || m_open) begin
            if (k == 5'd16) begin
                m_init = 0; m_open = 0; matched = 0;
            end
            return;
        end
        if (k == 5'd16) begin
            matched = 0;
        end else if (k < 5'd16) begin
            if (k[3:0] == code_digit(matched)) begin
                matched++;
                if (matched == 8) m_open = 1;
            end else begin
                m_alarm = 1;
            end
        end
    endtask

    // Called at a negedge: drive key, take one rising edge, check at next negedge.
    task automatic press(input logic [4:0] k, input string tag);
        keyout = k;
        model_step(k);
        @(negedge clk);
        check(tag, state, model_state());
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        model_reset();
        #1 check({tag, "_async"}, state, 4'd10);
        repeat (4) @(negedge clk);
        check(tag, state, 4'd10);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        // 1. reset, INIT holds with key 0
        keyout = 5'd0;
        reset_pulse("rst_init");
        press(5'd0, "init_hold0");
        press(5'd0, "init_hold1");
        // 2. LOCK arms entry
        press(5'd16, "init_to_ls0");
        // 3. full code, hold, relock
        for (int i = 1; i <= 8; i++) press(5'(i), $sformatf("code_d%0d", i));
        press(5'd8, "open_hold0");
        press(5'd8, "open_hold1");
        check("open_value", state, 4'd8);
        press(5'd16, "open_relock");
        // 4. wrong digit -> ALARM, sticky
        press(5'd1, "alm_d1");
        press(5'd2, "alm_d2");
        press(5'd6, "alm_wrong");
        check("alarm_value", state, 4'd9);
        press(5'd16, "alarm_lock_ign");
        press(5'd3, "alarm_key_ign");
        press(5'd31, "alarm_nokey");
        // 5. reset out of ALARM, then mid-entry reset
        reset_pulse("rst_alarm");
        press(5'd16, "rst5_lock");
        press(5'd1, "rst5_d1");
        reset_pulse("rst_midentry");
        press(5'd1, "post_rst_hold");
        // 6. no-key codes hold LS3, LOCK restarts
        press(5'd16, "ls3_arm");
        for (int i = 1; i <= 3; i++) press(5'(i), $sformatf("ls3_d%0d", i));
        for (int i = 0; i < 3; i++) press(5'd31, $sformatf("ls3_idle%0d", i));
        check("ls3_value", state, 4'd3);
        press(5'd16, "ls3_relock");
        // wrong zero digit raises ALARM
        seq = 32'h0A0B0C0D;
        press(5'd0, "zero_ok");
        press(5'd0, "zero_wrong");
        // asynchronous reset away from any edge
        #2 rst = 1'b1; model_reset();
        #1 check("async_mid", state, 4'd10);
        @(negedge clk); rst = 1'b0;

        // random traffic
        seq = $urandom;
        for (int it = 0; it < 3000; it++) begin
            int r;
            logic [4:0] k;
            if (m_alarm ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0)) begin
                reset_pulse($sformatf("rnd_rst%0d", it));
                continue;
            end
            if ((m_init || m_open) && $urandom_range(0, 3) == 0) seq = $urandom;
            r = $urandom_range(0, 99);
            if (!m_init && !m_open && !m_alarm && r < 70)
                k = {1'b0, code_digit(matched)};
            else if (r < 80)
                k = 5'd16;
            else if (r < 90)
                k = 5'($urandom_range(17, 31));
            else
                k = 5'($urandom_range(0, 15));
            press(k, $sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
